// File: rtl/wb_data_arbiter_pkg.sv
// Shared definitions for the Wishbone data-port arbiter: FSM encoding,
// data width, timeout read-data pattern and the per-master bus slice helper.
// The optional watchdog is enabled by defining WB_ARB_TIMEOUT_EN.
package wb_data_arbiter_pkg;

    localparam int DataWidth = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Read data returned to a master whose slave access timed out.
    localparam logic [DataWidth-1:0] DeadBeef = 32'hDEAD_BEEF;

    // Next round-robin start position after index idx, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        if (idx + 32'sd1 >= n) begin
            return 32'sd0;
        end else begin
            return idx + 32'sd1;
        end
    endfunction

endpackage

// Selects master k's 32-bit word from a packed per-master address/data bus.
`ifndef WB_ARB_WORD
`define WB_ARB_WORD(bus, k) bus[wb_data_arbiter_pkg::DataWidth*(k) +: wb_data_arbiter_pkg::DataWidth]
`endif

// File: rtl/wb_data_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: starting at rr_ptr and wrapping
// modulo N, the first asserted request wins. Shared with the fetch arbiter.
module wb_data_arbiter_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr_ptr,
    output logic [W-1:0] winner,
    output logic         valid
);

    logic [W-1:0] idx_s;

    // Scan requests from rr_ptr upward; the first hit is latched as winner.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx_s  = '0;
        for (int i = 0; i < N; i++) begin
            idx_s = W'((int'(rr_ptr) + i) % N);
            if (!valid && req[idx_s]) begin
                valid  = 1'b1;
                winner = idx_s;
            end else begin
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/wb_data_arbiter.sv
// Round-robin arbiter between NUM_MASTERS CPU data ports and one shared data
// memory. One master is granted per transaction; its request is forwarded to
// the slave and the slave's ack/read data are returned to that master only.
// Optional watchdog (define WB_ARB_TIMEOUT_EN): a silent slave is answered
// after TIMEOUT busy cycles with 32'hDEADBEEF and a sticky err_o.
module wb_data_arbiter
    import wb_data_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int GNT_W       = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    s_cyc_i,
    input  logic [NUM_MASTERS-1:0]    s_we_i,
    input  logic [NUM_MASTERS*32-1:0] s_adr_i,
    input  logic [NUM_MASTERS*32-1:0] s_dat_i,
    output logic [NUM_MASTERS-1:0]    s_ack_o,
    output logic [31:0]               s_dat_o,
    output logic                      m_cyc_o,
    output logic                      m_we_o,
    output logic [31:0]               m_adr_o,
    output logic [31:0]               m_dat_o,
    input  logic [31:0]               m_dat_i,
    input  logic                      m_ack_i,
    output logic [GNT_W-1:0]          gnt_o,
    output logic                      busy_o
`ifdef WB_ARB_TIMEOUT_EN
    ,
    output logic                      err_o
`endif
);

    // A parameter set that cannot be decoded safely never grants anybody.
    localparam bit ParamOk = (GNT_W == $clog2(NUM_MASTERS)) && (TIMEOUT > 0) &&
                             (NUM_MASTERS >= 2) && (NUM_MASTERS <= 8);

    arb_state_e             state_r, state_nxt_s;
    logic [GNT_W-1:0]       gnt_r, gnt_nxt_s;
    logic [GNT_W-1:0]       rr_ptr_r, rr_ptr_nxt_s;
    logic [GNT_W-1:0]       pick_winner_s;
    logic                   pick_valid_s;
    logic                   act_s;
    logic                   abort_s;
    logic                   timeout_s;
    logic [NUM_MASTERS-1:0] ack_vec_s;

    if (ParamOk) begin : g_pick
        wb_data_arbiter_rr_pick #(
            .N (NUM_MASTERS),
            .W (GNT_W)
        ) u_rr_pick (
            .req    (s_cyc_i),
            .rr_ptr (rr_ptr_r),
            .winner (pick_winner_s),
            .valid  (pick_valid_s)
        );
    end else begin : g_no_pick
        assign pick_winner_s = '0;
        assign pick_valid_s  = 1'b0;
    end

    // Reset masks the bus immediately so an in-flight ack is dropped.
    assign act_s     = (state_r == ST_BUSY) && !rst;
    assign abort_s   = !s_cyc_i[gnt_r] && !m_ack_i;
    assign ack_vec_s = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << gnt_r;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_r;
    logic            err_r;

    assign timeout_s = act_s && !m_ack_i && s_cyc_i[gnt_r] && (cnt_r == CntW'(TIMEOUT));
    assign err_o     = err_r;

    // Watchdog: counter held at zero in IDLE, counts busy cycles; error is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            err_r <= 1'b0;
        end else begin
            if (state_r == ST_IDLE) begin
                cnt_r <= '0;
            end else if (cnt_r != CntW'(TIMEOUT)) begin
                cnt_r <= cnt_r + CntW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // FSM state, current grant and round-robin start pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            gnt_r    <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            gnt_r    <= gnt_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    // Next-state decode plus slave-side mux and master-side ack/data return.
    always_comb begin
        state_nxt_s  = state_r;
        gnt_nxt_s    = gnt_r;
        rr_ptr_nxt_s = rr_ptr_r;
        m_cyc_o      = 1'b0;
        m_we_o       = 1'b0;
        m_adr_o      = 32'h0000_0000;
        m_dat_o      = 32'h0000_0000;
        s_ack_o      = '0;
        s_dat_o      = 32'h0000_0000;

        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s = ST_BUSY;
                    gnt_nxt_s   = pick_winner_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (m_ack_i || timeout_s || abort_s) begin
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = GNT_W'(rr_next(int'(gnt_r), NUM_MASTERS));
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (act_s) begin
            m_cyc_o = !abort_s;
            m_we_o  = s_we_i[gnt_r];
            m_adr_o = `WB_ARB_WORD(s_adr_i, gnt_r);
            m_dat_o = `WB_ARB_WORD(s_dat_i, gnt_r);
            if (m_ack_i) begin
                s_ack_o = ack_vec_s;
                s_dat_o = m_dat_i;
            end else if (timeout_s) begin
                s_ack_o = ack_vec_s;
                s_dat_o = DeadBeef;
            end else begin
                s_ack_o = '0;
                s_dat_o = 32'h0000_0000;
            end
        end else begin
            m_cyc_o = 1'b0;
        end
    end

    assign gnt_o  = gnt_r;
    assign busy_o = (state_r == ST_BUSY);

endmodule
